// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the decode/execute datapath and pipeline_hazard_ctrl.
// Optional feature macro: PHC_MEM_WAIT_EN (adds mem_busy).
//
// Handshake: this block has no valid/ready pair. Every datapath-side signal
// describes the instruction currently held in IF/ID or ID/EX and is sampled
// each cycle. Every controller-side enable or flush applies to the next
// rising edge of clk. The master (datapath) drives the instruction
// attributes. The slave (controller) drives the enables, flushes, status and
// the state_dbg view of its FSM.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // ID/EX instruction attributes
    logic             mem_read_de;
    logic             flag_write_de;
    logic [3:0]       dst_reg_de;

    // IF/ID instruction attributes
    logic [3:0]       rs_fd;
    logic [3:0]       rt_fd;
    logic             uses_rs_fd;
    logic             uses_rt_fd;
    logic             is_branch_fd;
    logic             branch_taken_fd;
    logic             hlt_fd;

`ifdef PHC_MEM_WAIT_EN
    logic             mem_busy;
`endif

    // Controller outputs
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             pipe_en;
    logic             halted;
    logic [CNT_W-1:0] stall_count;
    logic [1:0]       state_dbg;

`ifdef PHC_MEM_WAIT_EN
    modport master (
        output mem_read_de, flag_write_de, dst_reg_de,
        output rs_fd, rt_fd, uses_rs_fd, uses_rt_fd,
        output is_branch_fd, branch_taken_fd, hlt_fd, mem_busy,
        input  pc_en, ifid_en, ifid_flush, idex_flush, pipe_en,
        input  halted, stall_count, state_dbg
    );

    modport slave (
        input  mem_read_de, flag_write_de, dst_reg_de,
        input  rs_fd, rt_fd, uses_rs_fd, uses_rt_fd,
        input  is_branch_fd, branch_taken_fd, hlt_fd, mem_busy,
        output pc_en, ifid_en, ifid_flush, idex_flush, pipe_en,
        output halted, stall_count, state_dbg
    );
`else
    modport master (
        output mem_read_de, flag_write_de, dst_reg_de,
        output rs_fd, rt_fd, uses_rs_fd, uses_rt_fd,
        output is_branch_fd, branch_taken_fd, hlt_fd,
        input  pc_en, ifid_en, ifid_flush, idex_flush, pipe_en,
        input  halted, stall_count, state_dbg
    );

    modport slave (
        input  mem_read_de, flag_write_de, dst_reg_de,
        input  rs_fd, rt_fd, uses_rs_fd, uses_rt_fd,
        input  is_branch_fd, branch_taken_fd, hlt_fd,
        output pc_en, ifid_en, ifid_flush, idex_flush, pipe_en,
        output halted, stall_count, state_dbg
    );
`endif

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the five-stage core.
// It resolves load-use and flag-use stalls, squashes IF/ID on a taken branch,
// and drains the pipe after HLT. It also keeps a saturating stall counter.
// Optional feature macro: PHC_MEM_WAIT_EN. When defined, the bus has a
// mem_busy input that freezes the whole pipe, the FSM and the counters.
// CNT_W must match the CNT_W of the connected pipeline_hazard_ctrl_if.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // The drain counter only needs to hold DRAIN_CYCLES
    localparam int              DW         = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]   DRAIN_INIT = DW'(DRAIN_CYCLES);
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             state_q, state_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               halted_q, halted_d;

    logic               busy;
    logic               rs_match;
    logic               rt_match;
    logic               load_use;
    logic               flag_use;
    logic               hazard;

`ifdef PHC_MEM_WAIT_EN
    assign busy = bus.mem_busy;
`else
    assign busy = 1'b0;
`endif

    // Hazard detection: a load into R0 never stalls because R0 is hard-wired
    always_comb begin
        rs_match = bus.uses_rs_fd && (bus.rs_fd == bus.dst_reg_de);
        rt_match = bus.uses_rt_fd && (bus.rt_fd == bus.dst_reg_de);
        load_use = bus.mem_read_de && (bus.dst_reg_de != 4'd0) && (rs_match || rt_match);
        flag_use = bus.is_branch_fd && bus.flag_write_de;
        hazard   = load_use || flag_use;
    end

    // State register: FSM state, drain counter, stall counter and halted flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            drain_q  <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    // Next-state logic. A memory wait holds every register where it is.
    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        if (!busy) begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        // A stall cycle is counted; branch and HLT wait for re-decode
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (bus.hlt_fd) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_INIT;
                    end
                end
                ST_DRAIN: begin
                    // The last drain cycle hands over to HALTED; halted is registered with it
                    if (drain_q <= DRAIN_LAST) begin
                        state_d  = ST_HALTED;
                        drain_d  = '0;
                        halted_d = 1'b1;
                    end else begin
                        drain_d  = drain_q - DRAIN_LAST;
                    end
                end
                ST_HALTED: begin
                    halted_d = 1'b1;
                end
                default: begin
                    state_d  = ST_RUN;
                    drain_d  = '0;
                    halted_d = 1'b0;
                end
            endcase
        end
    end

    // Output logic (Mealy): enables and flushes follow the current inputs in the same cycle
    always_comb begin
        bus.pc_en      = 1'b1;
        bus.ifid_en    = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        bus.pipe_en    = 1'b1;
        if (busy) begin
            // Freeze everything; no flush so no instruction is lost
            bus.pc_en   = 1'b0;
            bus.ifid_en = 1'b0;
            bus.pipe_en = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        // Hold PC and IF/ID, insert one bubble into ID/EX
                        bus.pc_en      = 1'b0;
                        bus.ifid_en    = 1'b0;
                        bus.idex_flush = 1'b1;
                    end else if (bus.hlt_fd) begin
                        // HLT moves on into ID/EX; nothing behind it is fetched
                        bus.pc_en      = 1'b0;
                        bus.ifid_flush = 1'b1;
                    end else if (bus.branch_taken_fd) begin
                        // The branch path loads the PC; squash the fall-through fetch
                        bus.ifid_flush = 1'b1;
                    end
                end
                ST_DRAIN, ST_HALTED: begin
                    // Front end frozen; back end keeps retiring into bubbles
                    bus.pc_en      = 1'b0;
                    bus.ifid_en    = 1'b0;
                    bus.idex_flush = 1'b1;
                end
                default: begin
                    bus.pc_en   = 1'b0;
                    bus.ifid_en = 1'b0;
                end
            endcase
        end
    end

    // Registered status and FSM debug view
    always_comb begin
        bus.halted      = halted_q;
        bus.stall_count = cnt_q;
        bus.state_dbg   = state_q;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with DRAIN_CYCLES = 3 and CNT_W = 4.
// Inputs change 1 time unit after a rising edge. Outputs are sampled on the
// falling edge and compared against an expected-value queue.
// Expected word: {pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, halted, stall_count[3:0]}.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int W     = 10;

    // {pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, halted}
    localparam logic [5:0] C_RUN    = 6'b110010;
    localparam logic [5:0] C_STALL  = 6'b000110;
    localparam logic [5:0] C_HLT    = 6'b011010;
    localparam logic [5:0] C_BR     = 6'b111010;
    localparam logic [5:0] C_DRAIN  = 6'b000110;
    localparam logic [5:0] C_HALTED = 6'b000111;
    localparam logic [5:0] C_FREEZE = 6'b000000;

    logic clk;
    logic rst;
    logic busy_v;

    logic [W-1:0] exp_q[$];
    int           assert_cnt;
    int           fail_cnt;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES (3),
        .CNT_W        (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required end of test");
        $fatal(1, "watchdog expired");
    end

    // Packs {mr, fw, dst, rs, rt, urs, urt, br, bt, hlt}
    function automatic logic [18:0] f_in(input logic mr, input logic fw, input logic [3:0] dst,
                                         input logic [3:0] rs, input logic [3:0] rt,
                                         input logic urs, input logic urt, input logic br,
                                         input logic bt, input logic hlt);
        return {mr, fw, dst, rs, rt, urs, urt, br, bt, hlt};
    endfunction

    task automatic drive(input logic [18:0] v);
        bus.mem_read_de     = v[18];
        bus.flag_write_de   = v[17];
        bus.dst_reg_de      = v[16:13];
        bus.rs_fd           = v[12:9];
        bus.rt_fd           = v[8:5];
        bus.uses_rs_fd      = v[4];
        bus.uses_rt_fd      = v[3];
        bus.is_branch_fd    = v[2];
        bus.branch_taken_fd = v[1];
        bus.hlt_fd          = v[0];
`ifdef PHC_MEM_WAIT_EN
        bus.mem_busy        = busy_v;
`endif
    endtask

    task automatic expect_out(input logic [5:0] ctl, input logic [3:0] cnt);
        exp_q.push_back({ctl, cnt});
    endtask

    // Scoreboard: pop the oldest expectation and compare it with the DUT
    task automatic check(input string tag);
        logic [W-1:0] e;
        logic [W-1:0] obs;
        obs = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush,
               bus.pipe_en, bus.halted, bus.stall_count};
        assert_cnt++;
        if (exp_q.size() == 0) begin
            fail_cnt++;
            $display("FAIL %s: observed %b required a queued expectation", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                fail_cnt++;
                $error("FAIL %s: observed %b required %b", tag, obs, e);
            end
        end
    endtask

    task automatic step(input string tag, input logic [18:0] v,
                        input logic [5:0] ctl, input logic [3:0] cnt);
        @(posedge clk);
        #1;
        drive(v);
        expect_out(ctl, cnt);
        @(negedge clk);
        check(tag);
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any edge
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        drive('0);
        rst = 1'b1;
        #1;
        expect_out(C_RUN, 4'd0);
        check(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] d;
        assert_cnt = 0;
        fail_cnt   = 0;
        busy_v     = 1'b0;
        rst        = 1'b1;
        drive('0);

        // Reset state
        step("reset_state", '0, C_RUN, 4'd0);
        rst = 1'b0;

        step("idle", '0, C_RUN, 4'd0);

        // Load-use on rs, one bubble
        step("load_use_rs", f_in(1, 0, 4'd4, 4'd4, 4'd0, 1, 0, 0, 0, 0), C_STALL, 4'd0);
        step("after_load_use", '0, C_RUN, 4'd1);

        // Load-use on rt with a random register; rs matches but is unused
        d = 4'($urandom_range(1, 15));
        step("load_use_rt", f_in(1, 0, d, d, d, 0, 1, 0, 0, 0), C_STALL, 4'd1);
        step("after_rt", '0, C_RUN, 4'd2);

        // Non-stalling cases
        step("load_r0", f_in(1, 0, 4'd0, 4'd0, 4'd0, 1, 1, 0, 0, 0), C_RUN, 4'd2);
        step("load_unused_src", f_in(1, 0, 4'd4, 4'd4, 4'd4, 0, 0, 0, 0, 0), C_RUN, 4'd2);
        step("alu_dst_match", f_in(0, 0, 4'd4, 4'd4, 4'd0, 1, 0, 0, 0, 0), C_RUN, 4'd2);

        // Flag-use beats a taken branch, then the branch squashes
        step("flag_use_taken", f_in(0, 1, 4'd0, 4'd0, 4'd0, 0, 0, 1, 1, 0), C_STALL, 4'd2);
        step("branch_taken", f_in(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 1, 0), C_BR, 4'd3);
        step("flag_no_branch", f_in(0, 1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0), C_RUN, 4'd3);

        // Hazard beats HLT
        step("hazard_with_hlt", f_in(1, 0, 4'd9, 4'd9, 4'd0, 1, 0, 0, 0, 1), C_STALL, 4'd3);

        // HLT drain: halted rises on the 4th edge after HLT decode
        step("hlt", f_in(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1), C_HLT, 4'd4);
        step("drain_1", '0, C_DRAIN, 4'd4);
        step("drain_2", '0, C_DRAIN, 4'd4);
        step("drain_3", '0, C_DRAIN, 4'd4);
        step("halted_1", f_in(1, 0, 4'd4, 4'd4, 4'd0, 1, 0, 0, 0, 0), C_HALTED, 4'd4);
        step("halted_2", f_in(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 1, 1), C_HALTED, 4'd4);

        // Reset while halted, then again mid-drain
        async_reset("rst_halted");
        step("hlt_again", f_in(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1), C_HLT, 4'd0);
        step("drain_again", '0, C_DRAIN, 4'd0);
        async_reset("rst_mid_drain");
        step("run_after_rst", '0, C_RUN, 4'd0);

        // Saturation of the 4-bit counter
        d = 4'($urandom_range(1, 15));
        for (int i = 0; i < 20; i++) begin
            step("saturate", f_in(1, 0, d, 4'd0, d, 0, 1, 0, 0, 0), C_STALL,
                 (i > 15) ? 4'd15 : 4'(i));
        end
        step("sat_idle", '0, C_RUN, 4'd15);
        step("sat_stall_again", f_in(1, 0, d, d, 4'd0, 1, 0, 0, 0, 0), C_STALL, 4'd15);
        step("sat_hold", '0, C_RUN, 4'd15);

`ifdef PHC_MEM_WAIT_EN
        async_reset("rst_mem_wait");
        busy_v = 1'b1;
        step("busy_load_use", f_in(1, 0, 4'd5, 4'd5, 4'd0, 1, 0, 0, 0, 0), C_FREEZE, 4'd0);
        step("busy_idle", '0, C_FREEZE, 4'd0);
        busy_v = 1'b0;
        step("unbusy_load_use", f_in(1, 0, 4'd5, 4'd5, 4'd0, 1, 0, 0, 0, 0), C_STALL, 4'd0);
        step("busy_hlt_prep", '0, C_RUN, 4'd1);
        step("busy_hlt", f_in(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1), C_HLT, 4'd1);
        step("busy_drain_1", '0, C_DRAIN, 4'd1);
        busy_v = 1'b1;
        step("busy_freeze_1", '0, C_FREEZE, 4'd1);
        step("busy_freeze_2", '0, C_FREEZE, 4'd1);
        busy_v = 1'b0;
        step("busy_drain_2", '0, C_DRAIN, 4'd1);
        step("busy_drain_3", '0, C_DRAIN, 4'd1);
        step("busy_halted", '0, C_HALTED, 4'd1);
`endif

        // Leftover expectations mean a comparison was never made
        assert_cnt++;
        assert (exp_q.size() == 0) else begin
            fail_cnt++;
            $error("FAIL queue_empty: observed %0d entries required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the five-stage core. Sits beside the decode and execute stages. Watches the instruction in IF/ID and the instruction in ID/EX, and drives the PC and pipeline-register enables and flushes. Covers three cases forwarding cannot resolve: load-use and flag-use stalls, taken-branch squash, and HLT drain, plus a saturating stall-cycle counter.

## Interface
Parameters:
- DRAIN_CYCLES, default 3: cycles after HLT decode before `halted`, so instructions in EX, MEM and WB retire.
- CNT_W, default 16: width of the stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- mem_read_de  in  1  ID/EX instruction is a load.
- flag_write_de  in  1  ID/EX instruction updates flags (ALU `enable` is nonzero).
- dst_reg_de  in  4  ID/EX destination register.
- rs_fd, rt_fd  in  4 each  IF/ID source registers.
- uses_rs_fd, uses_rt_fd  in  1 each  IF/ID instruction reads rs / rt.
- is_branch_fd  in  1  IF/ID instruction is a conditional branch.
- branch_taken_fd  in  1  decode-resolved branch is taken.
- hlt_fd  in  1  IF/ID instruction is HLT.
- mem_busy  in  1  data memory wait. Present only with PHC_MEM_WAIT_EN.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID loads NOP.
- idex_flush  out  1  ID/EX loads bubble.
- pipe_en  out  1  ID/EX, EX/MEM and MEM/WB write enable.
- halted  out  1  pipeline drained after HLT.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation
- States: RUN, DRAIN, HALTED.
- load_use = mem_read_de & (dst_reg_de != 0) & ((uses_rs_fd & rs_fd == dst_reg_de) | (uses_rt_fd & rt_fd == dst_reg_de)).
- flag_use = is_branch_fd & flag_write_de.
- hazard = load_use | flag_use.
- Priority, highest first: mem_busy (macro only), hazard, hlt_fd, branch_taken_fd.

RUN behaviour:
- mem_busy: pc_en = ifid_en = pipe_en = 0, no flush, state held.
- hazard: pc_en = ifid_en = 0, idex_flush = 1, stall_count += 1. Decode re-evaluates next cycle, and branch/HLT are ignored this cycle.
- hlt_fd with no hazard: pc_en = 0, ifid_flush = 1, drain counter = DRAIN_CYCLES, go to DRAIN. The HLT itself proceeds into ID/EX.
- branch_taken_fd with no hazard: ifid_flush = 1. The PC is loaded by the branch path.
- Otherwise all enables are 1 and both flushes are 0.

DRAIN behaviour:
- pc_en = ifid_en = 0, idex_flush = 1, pipe_en = 1.
- Counter decrements each cycle. When it is 1, the next state is HALTED.
- The counter freezes while mem_busy is high (macro only).

HALTED behaviour:
- pc_en = ifid_en = 0, idex_flush = 1, pipe_en = 1, halted = 1.
- Left only by rst.

stall_count:
- Increments only on hazard stall cycles.
- Saturates at all-ones and does not wrap.
- mem_busy cycles are not counted.

## Timing
- Enable and flush outputs are combinational from the registered state and the current inputs (Mealy), so a stall takes effect the same cycle the hazard is present.
- One load-use or flag-use hazard costs exactly one bubble cycle.
- halted is registered and rises DRAIN_CYCLES + 1 edges after the edge that captured HLT in IF/ID.
- rst, including mid-DRAIN or while HALTED, asynchronously sets:
  - state = RUN, drain counter = 0, stall_count = 0, halted = 0.
  - With all other inputs 0: pc_en = ifid_en = pipe_en = 1 and ifid_flush = idex_flush = 0.
- A load to R0 never stalls.
- A hazard coincident with branch_taken_fd: stall only, no flush.

## Configuration
- PHC_MEM_WAIT_EN defined:
  - The mem_busy port exists.
  - mem_busy freezes every register enable with no flushes, and holds state, the drain counter and stall_count.
- PHC_MEM_WAIT_EN undefined:
  - The mem_busy port is absent.
  - pipe_en is 1 in every state.

## Test plan
- Load-use: mem_read_de = 1, dst_reg_de = 4, uses_rs_fd = 1, rs_fd = 4 for one cycle -> pc_en = 0, ifid_en = 0, idex_flush = 1 that cycle; stall_count 0 -> 1; next cycle (mem_read_de = 0) all enables 1.
- Load to R0: mem_read_de = 1, dst_reg_de = 0, rs_fd = 0 -> no stall; stall_count stays 0.
- Flag-use vs branch: is_branch_fd = 1, flag_write_de = 1, branch_taken_fd = 1 -> stall, ifid_flush = 0. Next cycle flag_write_de = 0 -> ifid_flush = 1, pc_en = 1.
- HLT: hlt_fd = 1 in RUN -> ifid_flush = 1, pc_en = 0. halted = 1 after 4 edges (DRAIN_CYCLES = 3) and stays 1. rst asserted mid-DRAIN -> halted = 0, pc_en = 1 immediately.
- Saturation, CNT_W = 4: hold load_use for 20 cycles -> stall_count reaches 15 and stays 15.
- With PHC_MEM_WAIT_EN: mem_busy = 1 during DRAIN for 2 cycles -> pipe_en = 0 and halted is delayed by exactly 2 cycles. mem_busy = 1 together with load_use -> no idex_flush and stall_count unchanged.
